softmax_job_sched: RTL and testbench

- Job scheduler and controller for one softmax engine (the p2 fixed-point pipeline: max, sub, exp, adder tree, ln, sub, exp).
- Accepts softmax jobs, given as a (start_addr, end_addr) pair, from NUM_REQ requesters and picks one with round-robin arbitration.
- Sequences the engine per job: engine reset, init, start, wait for done. Tags streamed outputs with the owner's id and reports completion or error.
- The engine reset before every job is mandatory: the engine's max register and adder-tree accumulator are cleared only by reset, so stale state from the previous job would corrupt the next one.

---
 rtl/softmax_job_sched_if.sv | 36 +++
 rtl/softmax_job_sched.sv | 109 ++++++++++
 tb/tb_softmax_job_sched.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/softmax_job_sched_if.sv
// Requester, engine and completion signals of the softmax job scheduler.
// The scheduler uses master; the requesters/engine side uses slave.
interface softmax_job_sched_if #(
    parameter int NUM_REQ  = 2,
    parameter int ID_W     = 1,
    parameter int ADDRSIZE = 9
);
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*ADDRSIZE-1:0] req_start_addr;
    logic [NUM_REQ*ADDRSIZE-1:0] req_end_addr;
    logic [NUM_REQ-1:0]          ack;
    logic                        eng_reset;
    logic                        eng_init;
    logic                        eng_start;
    logic [ADDRSIZE-1:0]         eng_start_addr;
    logic [ADDRSIZE-1:0]         eng_end_addr;
    logic                        eng_done;
    logic                        out_valid;
    logic [ID_W-1:0]             out_id;
    logic                        cmpl_valid;
    logic [ID_W-1:0]             cmpl_id;
    logic                        cmpl_err;
    logic                        busy;

    modport master (
        input  req, req_start_addr, req_end_addr, eng_done,
        output ack, eng_reset, eng_init, eng_start, eng_start_addr, eng_end_addr,
               out_valid, out_id, cmpl_valid, cmpl_id, cmpl_err, busy
    );

    modport slave (
        output req, req_start_addr, req_end_addr, eng_done,
        input  ack, eng_reset, eng_init, eng_start, eng_start_addr, eng_end_addr,
               out_valid, out_id, cmpl_valid, cmpl_id, cmpl_err, busy
    );
endinterface

// File: rtl/softmax_job_sched.sv
// Round-robin job scheduler for one softmax engine: arbitrates requesters,
// sequences engine reset/init/start/done, tags outputs and reports completion.
module softmax_job_sched #(
    parameter int NUM_REQ  = 2,
    parameter int ID_W     = 1,
    parameter int ADDRSIZE = 9,
    parameter int TIMEOUT  = 4096,
    parameter int TMO_W    = 16
) (
    input  logic clk,
    input  logic reset,
    softmax_job_sched_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_INIT, S_START, S_RUN, S_STREAM, S_CMPL
    } state_t;

    state_t              state, state_nx;
    logic [ID_W-1:0]     ptr, id_q, gnt_idx;
    logic                started;
    logic                gnt_found, job_ok, tmo_hit, err_q, eng_reset_q;
    logic [ADDRSIZE-1:0] start_q, end_q, sel_start, sel_end;
    logic [TMO_W-1:0]    wdog;

    // Scan from the highest offset down so the lowest offset from the base wins.
    // Until the first grant the base is 0 rather than ptr+1.
    always_comb begin : arb
        int base;
        int idx;
        base      = started ? int'(ptr) + 1 : 0;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sel_start = '0;
        sel_end   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = base + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (1'(bus.req >> idx)) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(idx);
                sel_start = ADDRSIZE'(bus.req_start_addr >> (idx * ADDRSIZE));
                sel_end   = ADDRSIZE'(bus.req_end_addr >> (idx * ADDRSIZE));
            end
        end
    end

    assign job_ok  = sel_end > sel_start;
    assign tmo_hit = (wdog == TMO_W'(TIMEOUT - 1));

    always_comb begin
        state_nx           = state;
        bus.ack            = '0;
        bus.eng_reset      = eng_reset_q;
        bus.eng_init       = (state == S_INIT);
        bus.eng_start      = (state == S_START);
        bus.eng_start_addr = start_q;
        bus.eng_end_addr   = end_q;
        // Engine outputs are valid whenever done is high after start, including
        // the RUN cycle in which done first rises.
        bus.out_valid      = (state == S_RUN || state == S_STREAM) && bus.eng_done && !tmo_hit;
        bus.out_id         = id_q;
        bus.cmpl_valid     = (state == S_CMPL);
        bus.cmpl_id        = id_q;
        bus.cmpl_err       = (state == S_CMPL) && err_q;
        bus.busy           = (state != S_IDLE);
        if (state == S_IDLE && gnt_found && reset)
            bus.ack = NUM_REQ'(1) << gnt_idx;
        case (state)
            S_IDLE:   if (gnt_found) state_nx = job_ok ? S_RST : S_CMPL;
            S_RST:    state_nx = S_INIT;
            S_INIT:   state_nx = S_START;
            S_START:  state_nx = S_RUN;
            S_RUN:    if (tmo_hit) state_nx = S_CMPL;
                      else if (bus.eng_done) state_nx = S_STREAM;
            S_STREAM: if (tmo_hit || !bus.eng_done) state_nx = S_CMPL;
            S_CMPL:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            eng_reset_q <= 1'b1;
            ptr         <= '0;
            started     <= 1'b0;
            id_q        <= '0;
            start_q     <= '0;
            end_q       <= '0;
            err_q       <= 1'b0;
            wdog        <= '0;
        end else begin
            state       <= state_nx;
            eng_reset_q <= (state_nx == S_RST);
            if (state == S_IDLE && gnt_found) begin
                ptr     <= gnt_idx;
                started <= 1'b1;
                id_q    <= gnt_idx;
                start_q <= sel_start;
                end_q   <= sel_end;
                err_q   <= !job_ok;
            end
            if ((state == S_RUN || state == S_STREAM) && tmo_hit) err_q <= 1'b1;
            if (state == S_START) wdog <= '0;
            else if (state == S_RUN || state == S_STREAM) wdog <= wdog + 1'b1;
        end
    end
endmodule

// File: tb/tb_softmax_job_sched.sv
// Directed bench for softmax_job_sched: job table plus hand-written
// contention, timeout and mid-job reset sequences.
module tb_softmax_job_sched;
    localparam int AW = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    softmax_job_sched_if #(.NUM_REQ(2), .ID_W(1), .ADDRSIZE(AW)) bus();

    softmax_job_sched #(
        .NUM_REQ(2), .ID_W(1), .ADDRSIZE(AW), .TIMEOUT(64), .TMO_W(16)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus.master)
    );

    typedef struct {
        int r; int sa; int ea; int dlat; int dlen; bit early; bit err;
    } vec_t;

    vec_t vecs[6];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input int sa, input int ea);
        bus.req[r] = 1'b1;
        bus.req_start_addr[r*AW +: AW] = AW'(sa);
        bus.req_end_addr[r*AW +: AW]   = AW'(ea);
    endtask

    // Starts in the cycle after ack, ends in the following IDLE cycle.
    task automatic job_body(input int id, input int sa, input int ea, input int dlat,
                            input int dlen, input bit early, input bit err);
        int ov = 0;
        logic [2*AW-1:0] save_sa, save_ea;
        if (err) begin
            #1;
            chk("cmpl_valid_err", bus.cmpl_valid, 1);
            chk("cmpl_id_err", bus.cmpl_id, id);
            chk("cmpl_err_set", bus.cmpl_err, 1);
            chk("no_eng_reset", bus.eng_reset, 0);
            chk("no_eng_init", bus.eng_init, 0);
            chk("no_eng_start", bus.eng_start, 0);
        end else begin
            bus.eng_done = early; #1;
            chk("rst_pulse", bus.eng_reset, 1);
            chk("rst_no_init", bus.eng_init, 0);
            chk("hold_sa_rst", bus.eng_start_addr, sa);
            cyc; bus.eng_done = early; #1;
            chk("init_pulse", bus.eng_init, 1);
            chk("init_no_rst", bus.eng_reset, 0);
            chk("init_no_start", bus.eng_start, 0);
            cyc; bus.eng_done = early; #1;
            chk("start_pulse", bus.eng_start, 1);
            chk("start_no_init", bus.eng_init, 0);
            cyc;
            save_sa = bus.req_start_addr;
            save_ea = bus.req_end_addr;
            for (int i = 0; i < dlat; i++) begin
                bus.eng_done = 1'b0;
                bus.req_start_addr = ~save_sa;
                bus.req_end_addr   = ~save_ea;
                #1;
                chk("hold_sa_run", bus.eng_start_addr, sa);
                chk("hold_ea_run", bus.eng_end_addr, ea);
                chk("ov_wait", bus.out_valid, 0);
                cyc;
            end
            bus.req_start_addr = save_sa;
            bus.req_end_addr   = save_ea;
            for (int i = 0; i < dlen; i++) begin
                bus.eng_done = 1'b1; #1;
                if (bus.out_valid && bus.out_id == 1'(id)) ov++;
                cyc;
            end
            bus.eng_done = 1'b0; #1;
            chk("ov_after", bus.out_valid, 0);
            chk("ov_count", ov, dlen);
            cyc; #1;
            chk("cmpl_valid", bus.cmpl_valid, 1);
            chk("cmpl_id", bus.cmpl_id, id);
            chk("cmpl_err_clr", bus.cmpl_err, 0);
            chk("cmpl_no_ack", bus.ack, 0);
        end
        cyc; #1;
        chk("idle_busy", bus.busy, 0);
        chk("idle_no_cmpl", bus.cmpl_valid, 0);
    endtask

    task automatic do_job(input vec_t v);
        set_req(v.r, v.sa, v.ea); #1;
        chk("ack", bus.ack, 1 << v.r);
        chk("ack_busy", bus.busy, 0);
        cyc; bus.req = '0;
        job_body(v.r, v.sa, v.ea, v.dlat, v.dlen, v.early, v.err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        vecs[0] = '{r:0, sa:0,   ea:8,   dlat:2, dlen:4, early:0, err:0};
        vecs[1] = '{r:1, sa:5,   ea:5,   dlat:0, dlen:0, early:0, err:1};
        vecs[2] = '{r:0, sa:10,  ea:511, dlat:1, dlen:1, early:1, err:0};
        vecs[3] = '{r:1, sa:300, ea:200, dlat:0, dlen:0, early:0, err:1};
        vecs[4] = '{r:1, sa:0,   ea:1,   dlat:0, dlen:3, early:0, err:0};
        vecs[5] = '{r:0, sa:511, ea:0,   dlat:0, dlen:0, early:0, err:1};

        bus.req = '0; bus.req_start_addr = '0; bus.req_end_addr = '0; bus.eng_done = 1'b0;
        cyc; bus.req = 2'b01; #1;
        chk("rst_eng_reset", bus.eng_reset, 1);
        chk("rst_ack", bus.ack, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_init", bus.eng_init, 0);
        chk("rst_start", bus.eng_start, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_cmpl", bus.cmpl_valid, 0);
        chk("rst_cmpl_err", bus.cmpl_err, 0);
        chk("rst_start_addr", bus.eng_start_addr, 0);
        bus.req = '0; rst_n = 1'b1;
        cyc; #1;
        chk("eng_reset_release", bus.eng_reset, 0);

        for (int i = 0; i < 6; i++) do_job(vecs[i]);

        // Watchdog: done never rises
        set_req(0, 0, 8); #1;
        chk("tmo_ack", bus.ack, 1);
        cyc; bus.req = '0; bus.eng_done = 1'b0;
        cyc; cyc; cyc;
        k = 0;
        while (k < 200) begin
            #1;
            if (bus.cmpl_valid) break;
            k++;
            cyc;
        end
        chk("tmo_latency", k, 64);
        chk("tmo_err", bus.cmpl_err, 1);
        chk("tmo_id", bus.cmpl_id, 0);
        cyc; #1;
        chk("tmo_busy", bus.busy, 0);
        do_job('{r:1, sa:2, ea:9, dlat:1, dlen:2, early:0, err:0});

        // Reset while streaming
        set_req(0, 0, 8); #1;
        chk("mid_ack", bus.ack, 1);
        cyc; bus.req = '0; cyc; cyc; cyc;
        bus.eng_done = 1'b1; #1;
        chk("mid_ov_run", bus.out_valid, 1);
        cyc; #1;
        chk("mid_ov_stream", bus.out_valid, 1);
        rst_n = 1'b0; #1;
        chk("mid_ov_async", bus.out_valid, 0);
        chk("mid_eng_reset", bus.eng_reset, 1);
        chk("mid_busy", bus.busy, 0);
        cyc; #1;
        chk("mid_no_cmpl", bus.cmpl_valid, 0);
        rst_n = 1'b1; bus.eng_done = 1'b0;
        cyc; #1;
        chk("mid_no_cmpl2", bus.cmpl_valid, 0);
        chk("mid_eng_reset_rel", bus.eng_reset, 0);

        // Contention right after reset: 0 first, then 1, then 0 again
        bus.req = 2'b11;
        bus.req_start_addr = {AW'(1), AW'(0)};
        bus.req_end_addr   = {AW'(3), AW'(4)};
        #1;
        chk("cont_ack0", bus.ack, 1);
        cyc; bus.req = 2'b10;
        job_body(0, 0, 4, 0, 1, 0, 0);
        chk("cont_ack1", bus.ack, 2);
        cyc; bus.req = '0;
        job_body(1, 1, 3, 0, 2, 0, 0);
        bus.req = 2'b11; #1;
        chk("cont_ack0_again", bus.ack, 1);
        cyc; bus.req = '0;
        job_body(0, 0, 4, 0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
